// File: rtl/mem_load_unit.sv
// mem_load_unit: M-stage load path. Issues one SRAM-like read per legal load,
// stalls the pipeline until the data returns, then formats the addressed
// byte/halfword/word for the W stage. Misaligned loads raise adel without
// touching the bus; a flushed load still completes on the bus but its data is
// discarded.
//
// state | meaning
// IDLE  | no load in flight; accepts a legal, aligned, unflushed load
// REQ   | data_req high, waiting for data_addr_ok
// WAIT  | address accepted, waiting for data_data_ok
// DONE  | load_result valid, held while pipe_stall_in is high
// DRAIN | load was flushed; swallow the returning data
module mem_load_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [5:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    input  logic              pipe_stall_in,
    output logic              data_req,
    output logic [ADDR_W-1:0] data_addr,
    output logic [1:0]        data_size,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              load_stall,
    output logic              load_done,
    output logic [DATA_W-1:0] load_result,
    output logic              adel,
    output logic [ADDR_W-1:0] badvaddr
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} stateType;

    stateType state, nextState;

    logic isLb, isLh, isLw, isLbu, isLhu, isLoad;
    logic misaligned, accept;
    logic [1:0] reqSize;
    logic reqSigned;
    logic signedReg;
    logic drop;
    logic [7:0] byteSel;
    logic [15:0] halfSel;
    logic [DATA_W-1:0] formatted;

    assign isLb   = (req_op == 6'b100000);
    assign isLh   = (req_op == 6'b100001);
    assign isLw   = (req_op == 6'b100011);
    assign isLbu  = (req_op == 6'b100100);
    assign isLhu  = (req_op == 6'b100101);
    assign isLoad = isLb | isLh | isLw | isLbu | isLhu;

    // Only legal load opcodes can be misaligned, so isLoad is implied here.
    assign misaligned = ((isLh | isLhu) & req_addr[0]) |
                        (isLw & (req_addr[1:0] != 2'b00));
    assign accept     = req_valid & isLoad & ~misaligned & ~flush & (state == IDLE);
    assign reqSize    = isLw ? 2'd2 : ((isLh | isLhu) ? 2'd1 : 2'd0);
    assign reqSigned  = isLb | isLh;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; a flushed load never reaches DONE
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) nextState = REQ;
            end
            REQ: begin
                if (data_addr_ok) begin
                    if (drop | flush) nextState = data_data_ok ? IDLE : DRAIN;
                    else              nextState = data_data_ok ? DONE : WAIT;
                end
            end
            WAIT: begin
                // Data arriving together with a flush is already the drained beat.
                if (data_data_ok) nextState = flush ? IDLE : DONE;
                else if (flush)   nextState = DRAIN;
            end
            DONE: begin
                if (flush | ~pipe_stall_in) nextState = IDLE;
            end
            DRAIN: begin
                if (data_data_ok) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Combinational outputs: stall and address-error reporting
    always_comb begin
        load_stall = accept | (state == REQ) | (state == WAIT) | (state == DRAIN);
        adel       = req_valid & (state == IDLE) & misaligned;
        badvaddr   = adel ? req_addr : '0;
    end

    // Byte/halfword extraction from the returned word using the captured address
    always_comb begin
        case (data_addr[1:0])
            2'd1:    byteSel = data_rdata[15:8];
            2'd2:    byteSel = data_rdata[23:16];
            2'd3:    byteSel = data_rdata[31:24];
            default: byteSel = data_rdata[7:0];
        endcase
        halfSel = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (data_size)
            2'd0:    formatted = {{24{signedReg & byteSel[7]}}, byteSel};
            2'd1:    formatted = {{16{signedReg & halfSel[15]}}, halfSel};
            default: formatted = data_rdata;
        endcase
    end

    // Registered bus request, captured request fields, drop flag and result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_req    <= 1'b0;
            data_addr   <= '0;
            data_size   <= 2'd0;
            signedReg   <= 1'b0;
            drop        <= 1'b0;
            load_done   <= 1'b0;
            load_result <= '0;
        end else begin
            data_req  <= (nextState == REQ);
            load_done <= (nextState == DONE);
            drop      <= (state == REQ) & (nextState == REQ) & (drop | flush);
            if (accept) begin
                data_addr <= req_addr;
                data_size <= reqSize;
                signedReg <= reqSigned;
            end
            if ((state != DONE) && (nextState == DONE)) begin
                load_result <= formatted;
            end
        end
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// tb_mem_load_unit: randomized and directed loads against a queue-based
// scoreboard; a monitor compares load_result whenever load_done is shown.
module tb_mem_load_unit;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [5:0]  req_op = 6'd0;
    logic [31:0] req_addr = 32'd0;
    logic        flush = 1'b0;
    logic        pipe_stall_in = 1'b0;
    logic        data_req;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'd0;
    logic        load_stall;
    logic        load_done;
    logic [31:0] load_result;
    logic        adel;
    logic [31:0] badvaddr;

    int nChecks = 0;
    int nPass = 0;
    logic [31:0] expQ[$];

    always #5 clk = ~clk;

    mem_load_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .flush(flush), .pipe_stall_in(pipe_stall_in),
        .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .load_stall(load_stall), .load_done(load_done),
        .load_result(load_result), .adel(adel), .badvaddr(badvaddr)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Reference: architectural MIPS load semantics written with shifts/masks
    function automatic logic [31:0] refLoad(logic [5:0] op, logic [31:0] addr, logic [31:0] rdata);
        logic [31:0] b, h;
        b = (rdata >> (8 * addr[1:0])) & 32'h0000_00FF;
        h = (rdata >> (16 * addr[1])) & 32'h0000_FFFF;
        case (op)
            OP_LB:   return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            OP_LHU:  return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [31:0] refSize(logic [5:0] op);
        if (op == OP_LW) return 32'd2;
        if (op == OP_LH || op == OP_LHU) return 32'd1;
        return 32'd0;
    endfunction

    function automatic bit refMisaligned(logic [5:0] op, logic [31:0] addr);
        if (op == OP_LW) return (addr % 4) != 0;
        if (op == OP_LH || op == OP_LHU) return (addr % 2) != 0;
        return 1'b0;
    endfunction

    // Monitor: compare each displayed result with the scoreboard head
    always @(negedge clk) begin
        #2;
        if (rst && load_done) begin
            if (expQ.size() == 0) begin
                nChecks++;
                $display("FAIL spurious_done: got load_done=1 result=%h expected load_done=0", load_result);
            end else begin
                check("load_result", load_result, expQ[0]);
                if (!pipe_stall_in || flush) void'(expQ.pop_front());
            end
        end
    end

    // mode: 0 normal, 1 flush in first REQ cycle, 2 flush in first WAIT cycle, 3 flush in DONE
    task automatic runLoad(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                           input int addrWait, input int dataWait, input int holdCycles, input int mode);
        int stallCnt = 0;
        int reqCnt = 0;
        int doneCnt = 0;
        bit flushed;
        logic [31:0] prevResult;
        flushed = (mode == 1) || (mode == 2);
        prevResult = load_result;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr;
        flush = 1'b0; pipe_stall_in = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1 stallCnt += int'(load_stall);
        check("adel_legal", {31'd0, adel}, 32'd0);
        @(posedge clk);
        for (int i = 0; i <= addrWait; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            data_addr_ok = (i == addrWait);
            data_data_ok = (i == addrWait) && (dataWait == 0);
            data_rdata = data_data_ok ? rdata : $urandom;
            flush = (mode == 1) && (i == 0);
            if (data_data_ok && !flushed) expQ.push_back(refLoad(op, addr, rdata));
            #1 stallCnt += int'(load_stall);
            reqCnt += int'(data_req);
            if (i == 0) begin
                check("data_addr", data_addr, addr);
                check("data_size", {30'd0, data_size}, refSize(op));
            end
            @(posedge clk);
        end
        for (int j = 1; j <= dataWait; j++) begin
            @(negedge clk);
            data_addr_ok = 1'b0;
            data_data_ok = (j == dataWait);
            data_rdata = data_data_ok ? rdata : $urandom;
            flush = (mode == 2) && (j == 1);
            req_valid = 1'b1; req_op = OP_LW; req_addr = $urandom & 32'hFFFF_FFFC;
            if (data_data_ok && !flushed) expQ.push_back(refLoad(op, addr, rdata));
            #1 stallCnt += int'(load_stall);
            reqCnt += int'(data_req);
            @(posedge clk);
        end
        for (int k = 0; k <= holdCycles; k++) begin
            @(negedge clk);
            req_valid = 1'b0; data_addr_ok = 1'b0;
            data_data_ok = (k == 0);
            data_rdata = $urandom;
            flush = (mode == 3) && (k == 0);
            pipe_stall_in = (k < holdCycles);
            #1 doneCnt += int'(load_done);
            stallCnt += int'(load_stall);
            @(posedge clk);
        end
        @(negedge clk);
        flush = 1'b0; pipe_stall_in = 1'b0; data_data_ok = 1'b0;
        check("stall_cycles", stallCnt, 2 + addrWait + dataWait);
        check("req_cycles", reqCnt, addrWait + 1);
        check("done_cycles", doneCnt, flushed ? 0 : ((mode == 3) ? 1 : holdCycles + 1));
        if (flushed) check("result_kept", load_result, prevResult);
    endtask

    // Present a non-accepted request (misaligned or non-load opcode)
    task automatic checkReject(input logic [5:0] op, input logic [31:0] addr);
        bit mis;
        mis = refMisaligned(op, addr);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr;
        #1 check("adel", {31'd0, adel}, {31'd0, mis});
        check("badvaddr", badvaddr, mis ? addr : 32'd0);
        check("reject_stall", {31'd0, load_stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1 check("reject_no_req", {30'd0, data_req, load_stall}, 32'd0);
    endtask

    logic [5:0] ops[5] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};

    initial begin
        logic [5:0]  op;
        logic [31:0] addr;
        int mode, dw;
        #2 rst = 1'b0;
        #1 check("rst_ctrl", {28'd0, data_req, load_done, load_stall, adel}, 32'd0);
        check("rst_addr", data_addr, 32'd0);
        check("rst_size", {30'd0, data_size}, 32'd0);
        check("rst_result", load_result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        runLoad(OP_LW, 32'h1000, 32'hDEAD_BEEF, 1, 3, 0, 0);
        check("lw_const", load_result, 32'hDEAD_BEEF);
        runLoad(OP_LB, 32'h1003, 32'h8012_3456, 0, 1, 0, 0);
        check("lb_const", load_result, 32'hFFFF_FF80);
        runLoad(OP_LBU, 32'h1003, 32'h8012_3456, 1, 0, 0, 0);
        check("lbu_const", load_result, 32'h0000_0080);
        runLoad(OP_LH, 32'h1002, 32'h8012_3456, 0, 2, 0, 0);
        check("lh_const", load_result, 32'hFFFF_8012);
        runLoad(OP_LHU, 32'h1002, 32'h8012_3456, 2, 1, 0, 0);
        check("lhu_const", load_result, 32'h0000_8012);

        checkReject(OP_LW, 32'h1002);
        checkReject(OP_LH, 32'h1001);
        checkReject(6'b101011, 32'h1000);

        runLoad(OP_LW, 32'h3000, 32'h1234_5678, 0, 4, 0, 2);
        runLoad(OP_LW, 32'h3004, 32'hCAFE_F00D, 0, 1, 0, 0);
        runLoad(OP_LW, 32'h4000, 32'h0BAD_F00D, 0, 0, 3, 0);
        runLoad(OP_LH, 32'h4002, 32'h5555_AAAA, 1, 0, 0, 1);
        runLoad(OP_LB, 32'h4001, 32'h5555_AAAA, 1, 2, 0, 1);
        runLoad(OP_LBU, 32'h4001, 32'h1234_F0CD, 0, 1, 2, 3);

        // Reset while waiting for data
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h5000;
        @(negedge clk);
        req_valid = 1'b0; data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        #3 rst = 1'b0;
        #1 check("arst_ctrl", {28'd0, data_req, load_done, load_stall, adel}, 32'd0);
        check("arst_addr", data_addr, 32'd0);
        check("arst_size", {30'd0, data_size}, 32'd0);
        check("arst_result", load_result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1 check("post_rst_idle", {30'd0, data_req, load_stall}, 32'd0);
        end
        runLoad(OP_LW, 32'h5004, 32'h7777_1111, 0, 1, 0, 0);

        for (int t = 0; t < 40; t++) begin
            op = ops[$urandom_range(0, 4)];
            addr = $urandom;
            if (refMisaligned(op, addr)) begin
                checkReject(op, addr);
            end else begin
                dw = $urandom_range(0, 3);
                mode = $urandom_range(0, 3);
                if (mode == 2 && dw < 2) mode = 0;
                runLoad(op, addr, $urandom, $urandom_range(0, 3), dw, $urandom_range(0, 2), mode);
            end
        end

        repeat (2) @(negedge clk);
        check("queue_empty", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
